// File: rtl/arb_queue_n.sv
`default_nettype none
// ----------------------------------------------------------------------
// arb_queue_n: NREQ-way arbiter serving requests in FIFO arrival order
// Rev 1.0 - initial release
// ----------------------------------------------------------------------
module arb_queue_n #(
  parameter int NREQ     = 4,
  parameter int RR_EN    = 0,
  parameter int MAX_HOLD = 0,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(NREQ + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] request,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx,
  output logic [CW-1:0]   queue_count,
  output logic            busy
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   req_q;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     grant_idx_q, grant_idx_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [NREQ-1:0]   queued_q, queued_d;
  logic [IW-1:0]     mem_q [NREQ];
  logic [IW-1:0]     mem_d [NREQ];

  logic [NREQ-1:0]   pending;
  logic              push;
  logic [IW-1:0]     push_idx;
  logic              pop;
  logic [IW-1:0]     head;
  logic [CW-1:0]     push_pos;

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = grant_idx_q;
  assign queue_count = count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign head        = mem_q[0];

  // The current owner is excluded only while it actually holds the grant,
  // so a preempted owner re-enters the queue during RELEASE.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = req_q[i] & ~queued_q[i] & ~(grant_valid & (grant_idx_q == IW'(i)));
    end
  end

  always_comb begin : p_select
    int j;
    j        = 0;
    push     = 1'b0;
    push_idx = '0;
    if (RR_EN != 0) begin
      // Walk distances from farthest to nearest so the nearest index after rr_ptr wins.
      for (int k = NREQ; k >= 1; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NREQ) j = j - NREQ;
        if (pending[IW'(j)]) begin
          push     = 1'b1;
          push_idx = IW'(j);
        end
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (pending[i]) begin
          push     = 1'b1;
          push_idx = IW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          // A withdrawn head is simply dropped without a grant.
          if (req_q[head]) begin
            grant_d       = '0;
            grant_d[head] = 1'b1;
            grant_idx_d   = head;
            hold_cnt_d    = HW'(1);
            state_d       = S_GRANT;
          end
        end
      end
      S_GRANT: begin
        if (!req_q[grant_idx_q]) begin
          grant_d     = '0;
          grant_idx_d = '0;
          state_d     = S_RELEASE;
        end else if ((MAX_HOLD > 0) && (hold_cnt_q == MAX_HOLD_C) && (count_q != '0)) begin
          grant_d     = '0;
          grant_idx_d = '0;
          state_d     = S_RELEASE;
        end else if (hold_cnt_q < MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (push && (RR_EN != 0)) rr_ptr_d = push_idx;
  end

  // Queue storage: pop shifts toward the head, push lands after the shift.
  always_comb begin
    push_pos = count_q - CW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    queued_d = queued_q;
    for (int i = 0; i < NREQ; i++) mem_d[i] = mem_q[i];
    if (pop) begin
      for (int i = 0; i < NREQ - 1; i++) mem_d[i] = mem_q[i + 1];
      mem_d[NREQ-1]  = '0;
      queued_d[head] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < NREQ; i++) begin
        if (CW'(i) == push_pos) mem_d[i] = push_idx;
      end
      queued_d[push_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      count_q     <= '0;
      queued_q    <= '0;
      for (int i = 0; i < NREQ; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= request;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      queued_q    <= queued_d;
      for (int i = 0; i < NREQ; i++) mem_q[i] <= mem_d[i];
    end
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(push && (count_q == CW'(NREQ))));

endmodule
`default_nettype wire

// File: doc/arb_queue_n.md
# arb_queue_n

Parametrised request arbiter with a FIFO service queue: next generation of the 4-requester queue-based arbiter, generalised to NREQ requesters, with selectable fixed-priority or round-robin enqueue order and optional hold-time preemption. Requests are sampled, queued in arrival order (at most one enqueue per cycle), and served one at a time with a registered one-hot grant. The block sits between shared-resource clients and the resource's select logic.

## Interface
- NREQ, 4, number of requesters; legal 2..16.
- RR_EN, 0, enqueue order among simultaneous new requesters: 0 = lowest index first, 1 = round-robin.
- MAX_HOLD, 0, max GRANT cycles before forced release when others wait; 0 disables preemption.
- IW (derived), clog2(NREQ); CW (derived), clog2(NREQ+1).

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- request  in  NREQ  level request per client.
- grant  out  NREQ  registered one-hot grant; all-zero when no owner.
- grant_valid  out  1  |grant.
- grant_idx  out  IW  index of current owner; 0 when grant_valid=0.
- queue_count  out  CW  entries in queue, 0..NREQ.
- busy  out  1  state != IDLE or queue_count != 0.

## Operation
- Reset values: grant=0, grant_idx=0, queue_count=0, busy=0, req_q=0, state IDLE, hold_cnt=0, rr_ptr=NREQ-1.
- req_q: request registered once per cycle; all decisions use req_q, never raw request.
- queued[i]: i is in the queue. pending[i] = req_q[i] & ~queued[i] & ~(owner==i & grant_valid).
- Enqueue: each cycle at most one pending index pushed to tail. RR_EN=0: lowest pending index. RR_EN=1: first pending index strictly after rr_ptr (wrapping NREQ-1 -> 0); rr_ptr <= enqueued index.
- Queue depth NREQ; each index appears at most once, so overflow is impossible. Assertion: push with queue_count==NREQ never occurs.
- States: IDLE, GRANT, RELEASE.
- IDLE: if queue_count>0, pop head h. If req_q[h]=1: grant<=onehot(h), grant_idx<=h, hold_cnt<=1, -> GRANT. If req_q[h]=0 (client withdrew while queued): entry discarded, stay IDLE, no grant.
- GRANT: if req_q[owner]=0 -> grant<=0, -> RELEASE. Else if MAX_HOLD>0, hold_cnt==MAX_HOLD and queue_count>0 -> grant<=0, -> RELEASE (preempted; owner becomes pending and is re-enqueued at tail next cycle if still requesting). Else hold_cnt increments, saturating at MAX_HOLD.
- RELEASE: one turnaround cycle with grant=0, -> IDLE.
- Simultaneous pop and push in the same cycle: pop removes head, pushed entry lands at tail after shift; queue_count unchanged.
- Push into empty queue is not popped in the same cycle; pop occurs next IDLE cycle.
- Preemption check uses queue_count before this cycle's push.

## Timing
- Request rise sampled at edge 1 (req_q=1); enqueued at edge 2 (queue_count=1); popped and granted at edge 3, idle arbiter with empty queue: 3-cycle latency.
- Request fall sampled at edge k; grant drops at edge k+1 (RELEASE); IDLE at k+2; next grant earliest at k+3.
- grant, grant_idx, grant_valid change only on clock edges or asynchronously on reset.
- Reset mid-operation: queue flushed, grant cleared asynchronously; first grant after deassertion follows the 3-cycle rule.
- hold_cnt width clog2(MAX_HOLD+1); preemption at end of the MAX_HOLD-th GRANT cycle.

## Test plan
- NREQ=4, RR_EN=0: request=4'b0001 from reset release -> grant=0001 after 3rd edge, queue_count 0->1->0; drop request -> grant=0 two edges later, busy=0 after RELEASE.
- NREQ=4, RR_EN=0: request=4'b1110 in one cycle -> enqueue order 1,2,3; grants 0010, 0100, 1000 in sequence as each drops its request.
- NREQ=4, RR_EN=1, rr_ptr=2 after serving 2: request=4'b0111 -> enqueue order 0,1,2 (wrap after pointer).
- MAX_HOLD=3: client 0 holds, client 1 requests -> grant 0001 drops after 3 GRANT cycles, client 1 granted, client 0 re-queued and granted after client 1 releases.
- Withdrawal: clients 0 and 2 queued, client 2 deasserts before served -> entry discarded, grant never 0100, queue_count reaches 0.
- Reset asserted during GRANT with queue_count=3 -> grant=0, queue_count=0 immediately, before next edge.
